fetch: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register; the stage directly upstream of decode.
- Holds the PC and selects the next PC: sequential PC+4, or a redirect target from execute.
- Drives the instruction-memory address and qualifies the returned word with a memory-ready handshake.
- Registers instruction, PC and PC+4 into decode, with stall, flush and bubble insertion, so decode always sees a valid instruction or a canonical NOP.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch.sv | 81 ++++++++
 tb/tb_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the IF/ID payload type used by fetch and decode.
// Decode reuses RV_NOP_INSTR when it squashes an instruction.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, a missed fetch becomes a bubble.
// One-cycle latency; downstream stall is absorbed by holding the current contents.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall_i,
    input  logic  flush_i,
    input  logic  capture_i,
    input  ifid_t fetch_i,
    output ifid_t ifid_o
);

    ifid_t ifid_q, ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = ifid_bubble(NOP_INSTR);
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (!capture_i) begin
            ifid_d = ifid_bubble(NOP_INSTR);
        end else begin
            ifid_d       = fetch_i;
            ifid_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= ifid_bubble(NOP_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC register, next-PC select and the IF/ID register feeding decode.
// Word returned for PCF lands in IF/ID one cycle later; stalls and memory wait hold PCF.
module fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [XLEN-1:0] PCF
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_ok;
    ifid_t           fetch_word;
    ifid_t           ifid;

    assign pc_plus4 = pc_q + 32'd4;
    assign fetch_ok = imem_ready & ~StallF;

    // Redirect overrides both stall and memory wait; PCF only moves on capture or redirect.
    always_comb begin
        pc_d = pc_q;
        if (PCSrcE) begin
            pc_d = PCTargetE;
        end else if (fetch_ok) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fetch_word.instr    = imem_rdata;
    assign fetch_word.pc       = pc_q;
    assign fetch_word.pc_plus4 = pc_plus4;
    assign fetch_word.valid    = 1'b1;

    // The word in flight belongs to the path being abandoned on a redirect.
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (StallD),
        .flush_i   (FlushD | PCSrcE),
        .capture_i (fetch_ok),
        .fetch_i   (fetch_word),
        .ifid_o    (ifid)
    );

    assign imem_addr = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = ifid.instr;
    assign PCD       = ifid.pc;
    assign PCPlus4D  = ifid.pc_plus4;
    assign ValidD    = ifid.valid;

    // Holding decode while fetch advances would drop an instruction.
    a_stall_contract: assert property (@(posedge clk) disable iff (!rst_n) !(StallD && !StallF));

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE, imem_ready;
    logic [31:0] PCTargetE, imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D, PCF;
    logic        ValidD;
    logic        hash_mode;

    int checks = 0;
    int errors = 0;

    // Reference state: what decode should be holding and where fetch should be.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_vld;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a, input logic h);
        return h ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) : a;
    endfunction

    assign imem_rdata = memf(imem_addr, hash_mode);

    fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .PCF        (PCF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_vld = 1'b0;
    endtask

    // One clock of the pipeline as described in words: what decode gets, then where fetch goes.
    task automatic model_edge();
        bit delivered = imem_ready && !StallF;
        if (FlushD || PCSrcE) begin
            m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_vld = 0;
        end else if (StallD) begin
            // decode keeps what it has
        end else if (!delivered) begin
            m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_vld = 0;
        end else begin
            m_instr = memf(m_pc, hash_mode); m_pcd = m_pc; m_pc4d = m_pc + 4; m_vld = 1;
        end
        if (PCSrcE) m_pc = PCTargetE;
        else if (delivered) m_pc = m_pc + 4;
    endtask

    task automatic compare_model();
        chk("PCF", PCF, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pc4d);
        chk("ValidD", {31'b0, ValidD}, {31'b0, m_vld});
        if (m_vld) chk("instr_of_pcd", InstrD, memf(PCD, hash_mode));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; imem_ready = 1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE = 1; PCTargetE = tgt;
        step();
        PCSrcE = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_PCF"}, PCF, 32'h0);
        chk({tag, "_InstrD"}, InstrD, NOP);
        chk({tag, "_PCD"}, PCD, 32'h0);
        chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
        chk({tag, "_ValidD"}, {31'b0, ValidD}, 32'h0);
    endtask

    initial begin
        rst_n = 0; hash_mode = 0; PCTargetE = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1;

        // Sequential fetch, word = address.
        step();
        chk("seq0_InstrD", InstrD, 32'h0); chk("seq0_Valid", {31'b0, ValidD}, 32'h1);
        step();
        chk("seq1_PCD", PCD, 32'h4); chk("seq1_PC4", PCPlus4D, 32'h8);
        step();
        chk("seq2_InstrD", InstrD, 32'h8);
        step();
        chk("seq3_PCF", PCF, 32'h10);

        // Redirect at PCF=0x10; 0x10 must never reach decode.
        redirect(32'h100);
        chk("redir_PCF", PCF, 32'h100); chk("redir_bubble", InstrD, NOP);
        chk("redir_Valid", {31'b0, ValidD}, 32'h0);
        step();
        chk("redir_PCD", PCD, 32'h100); chk("redir_Valid2", {31'b0, ValidD}, 32'h1);

        // Stall both stages for three cycles at 0x20.
        redirect(32'h20);
        StallF = 1; StallD = 1;
        repeat (3) step();
        chk("stall_PCF", PCF, 32'h20);
        StallF = 0; StallD = 0;
        step();
        chk("stall_rel_PCD", PCD, 32'h20);
        step();
        chk("stall_rel_PCD2", PCD, 32'h24);

        // Memory not ready for two cycles at 0x40.
        redirect(32'h40);
        imem_ready = 0;
        step();
        chk("nrdy_bubble1", InstrD, NOP);
        step();
        chk("nrdy_PCF", PCF, 32'h40);
        imem_ready = 1;
        step();
        chk("nrdy_PCD", PCD, 32'h40);
        step();
        chk("nrdy_PCD2", PCD, 32'h44);

        // Flush beats decode stall.
        StallF = 1; StallD = 1; FlushD = 1;
        step();
        chk("flush_vs_stall", {31'b0, ValidD}, 32'h0);
        idle_inputs();

        // Redirect beats fetch stall.
        StallF = 1;
        redirect(32'h200);
        chk("redir_vs_stall", PCF, 32'h200);
        StallF = 0;

        // PC wraps past the top of the address space.
        redirect(32'hFFFF_FFFC);
        step();
        chk("wrap_PCF", PCF, 32'h0); chk("wrap_PC4D", PCPlus4D, 32'h0);

        // Asynchronous reset mid-stream at PCF=0x80.
        redirect(32'h7C);
        step();
        chk("pre_rst_PCF", PCF, 32'h80);
        rst_n = 0;
        #1;
        chk_reset_values("async_rst");
        model_reset();
        #2 rst_n = 1;
        step();
        chk("restart_PCD", PCD, 32'h0);

        // Randomised traffic with scrambled memory contents.
        hash_mode = 1;
        for (int i = 0; i < 400; i++) begin
            StallF     = ($urandom_range(0, 5) == 0);
            StallD     = StallF && ($urandom_range(0, 1) == 1);
            FlushD     = ($urandom_range(0, 11) == 0);
            PCSrcE     = ($urandom_range(0, 9) == 0);
            PCTargetE  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                     : ($urandom & 32'hFFFF_FFFC);
            imem_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
